// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard control: forwarding selects, load-use bubbles and
// pipeline freeze for multi-cycle EX operations.
module ex_hazard_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_dst_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_multi,
    output logic             stall,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic [1:0]       rs_fwd_sel,
    output logic [1:0]       rt_fwd_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    localparam logic [4:0] MC_LOAD = 5'(MC_CYCLES - 1);

    slot_t      ex_q;
    slot_t      mem_q;
    logic [4:0] mc_cnt;

    logic       hold;
    logic       lu;
    logic       accept;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;

    function automatic logic hits(slot_t s, logic [4:0] r);
        return s.valid & s.reg_write & (s.dst != 5'd0) & (s.dst == r);
    endfunction

    always_comb begin
        hold   = (mc_cnt != 5'd0);
        lu     = id_valid & ex_q.valid & ex_q.mem_read &
                 ((id_use_rs & hits(ex_q, id_rs)) |
                  (id_use_rt & hits(ex_q, id_rt)));
        accept = id_valid & ~lu;
        rs_sel = 2'd0;
        rt_sel = 2'd0;
        // The instruction now in EX will sit in MEM when the ID one reaches EX
        if (id_use_rs) begin
            if (hits(ex_q, id_rs))       rs_sel = 2'd1;
            else if (hits(mem_q, id_rs)) rs_sel = 2'd2;
        end
        if (id_use_rt) begin
            if (hits(ex_q, id_rt))       rt_sel = 2'd1;
            else if (hits(mem_q, id_rt)) rt_sel = 2'd2;
        end
    end

    assign ex_hold      = hold;
    assign stall        = hold | lu;
    assign id_ex_bubble = ~hold & (lu | ~id_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            mem_q      <= '0;
            mc_cnt     <= 5'd0;
            rs_fwd_sel <= 2'd0;
            rt_fwd_sel <= 2'd0;
            stall_cnt  <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (hold) begin
                mc_cnt <= mc_cnt - 5'd1;
                mem_q  <= '0;
            end else begin
                mem_q           <= ex_q;
                ex_q.valid      <= accept;
                ex_q.dst        <= id_dst_reg;
                ex_q.reg_write  <= id_reg_write;
                ex_q.mem_read   <= id_mem_read;
                rs_fwd_sel      <= accept ? rs_sel : 2'd0;
                rt_fwd_sel      <= accept ? rt_sel : 2'd0;
                mc_cnt          <= (accept & id_multi) ? MC_LOAD : 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl; expected outputs are queued per
// step and popped against the DUT each cycle.
module tb_ex_hazard_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [4:0]    id_dst_reg;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_multi;
    logic          stall;
    logic          id_ex_bubble;
    logic          ex_hold;
    logic [1:0]    rs_fwd_sel;
    logic [1:0]    rt_fwd_sel;
    logic [CW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    ex_hazard_ctrl #(.MC_CYCLES(4), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_dst_reg   (id_dst_reg),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_multi     (id_multi),
        .stall        (stall),
        .id_ex_bubble (id_ex_bubble),
        .ex_hold      (ex_hold),
        .rs_fwd_sel   (rs_fwd_sel),
        .rt_fwd_sel   (rt_fwd_sel),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic       mu;
    } ins_t;

    typedef struct {
        string         tag;
        logic          st;
        logic          bu;
        logic          ho;
        logic [1:0]    rs;
        logic [1:0]    rt;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    function automatic ins_t alu(logic [4:0] d, logic [4:0] s, logic [4:0] t);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rs = s; i.rt = t; i.urs = 1'b1; i.urt = 1'b1;
        i.dst = d; i.rw = 1'b1;
        return i;
    endfunction

    function automatic ins_t mul(logic [4:0] d, logic [4:0] s, logic [4:0] t);
        ins_t i;
        i = alu(d, s, t);
        i.mu = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(logic [4:0] d, logic [4:0] b, logic m);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rs = b; i.rt = d; i.urs = 1'b1;
        i.dst = d; i.rw = 1'b1; i.mr = 1'b1; i.mu = m;
        return i;
    endfunction

    function automatic ins_t nop();
        return '0;
    endfunction

    task automatic drive(ins_t i);
        id_valid     = i.v;
        id_rs        = i.rs;
        id_rt        = i.rt;
        id_use_rs    = i.urs;
        id_use_rt    = i.urt;
        id_dst_reg   = i.dst;
        id_reg_write = i.rw;
        id_mem_read  = i.mr;
        id_multi     = i.mu;
    endtask

    task automatic chk(string tag, string fld, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s got=%0d want=%0d", tag, fld, obs, exp);
        end
    endtask

    task automatic step(string tag, ins_t i, logic e_st, logic e_bu,
                        logic e_ho, logic [1:0] e_rs, logic [1:0] e_rt,
                        logic [CW-1:0] e_cnt);
        exp_t e;
        drive(i);
        e.tag = tag; e.st = e_st; e.bu = e_bu; e.ho = e_ho;
        e.rs = e_rs; e.rt = e_rt; e.cnt = e_cnt;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk(e.tag, "stall",  int'(stall),        int'(e.st));
        chk(e.tag, "bubble", int'(id_ex_bubble), int'(e.bu));
        chk(e.tag, "hold",   int'(ex_hold),      int'(e.ho));
        chk(e.tag, "rs_sel", int'(rs_fwd_sel),   int'(e.rs));
        chk(e.tag, "rt_sel", int'(rt_fwd_sel),   int'(e.rt));
        chk(e.tag, "cnt",    int'(stall_cnt),    int'(e.cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ec;
        rst = 1'b1;
        drive(nop());
        repeat (2) @(posedge clk);
        #1;
        step("reset", alu(5'd1, 5'd2, 5'd3), 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // back-to-back
        step("b2b_add", alu(5'd3, 5'd1, 5'd2), 0, 0, 0, 0, 0, 0);
        step("b2b_sub", alu(5'd4, 5'd3, 5'd5), 0, 0, 0, 0, 0, 0);
        step("b2b_ex",  nop(),                 0, 1, 0, 1, 0, 0);

        // distance two, double match
        step("d2_add",  alu(5'd3, 5'd1, 5'd2), 0, 0, 0, 0, 0, 0);
        step("d2_nop",  nop(),                 0, 1, 0, 0, 0, 0);
        step("d2_or",   alu(5'd6, 5'd3, 5'd3), 0, 0, 0, 0, 0, 0);
        step("d2_ex",   nop(),                 0, 1, 0, 2, 2, 0);

        // EX priority over MEM
        step("pr_add1", alu(5'd3, 5'd1, 5'd2), 0, 0, 0, 0, 0, 0);
        step("pr_add2", alu(5'd3, 5'd4, 5'd5), 0, 0, 0, 0, 0, 0);
        step("pr_or",   alu(5'd6, 5'd3, 5'd3), 0, 0, 0, 0, 0, 0);
        step("pr_ex",   nop(),                 0, 1, 0, 1, 1, 0);

        // load-use
        step("lu_lw",   lw(5'd2, 5'd8, 1'b0),  0, 0, 0, 0, 0, 0);
        step("lu_bub",  alu(5'd7, 5'd2, 5'd2), 1, 1, 0, 0, 0, 0);
        step("lu_go",   alu(5'd7, 5'd2, 5'd2), 0, 0, 0, 0, 0, 1);
        step("lu_ex",   nop(),                 0, 1, 0, 2, 2, 1);

        // register zero
        step("r0_lw",   lw(5'd0, 5'd1, 1'b0),  0, 0, 0, 0, 0, 1);
        step("r0_rd1",  alu(5'd5, 5'd0, 5'd0), 0, 0, 0, 0, 0, 1);
        step("r0_rd2",  alu(5'd6, 5'd0, 5'd0), 0, 0, 0, 0, 0, 1);
        step("r0_ex",   nop(),                 0, 1, 0, 0, 0, 1);

        // multi-cycle load with consumer waiting in ID
        step("ml_lw",   lw(5'd2, 5'd8, 1'b1),  0, 0, 0, 0, 0, 1);
        step("ml_h1",   alu(5'd7, 5'd2, 5'd2), 1, 0, 1, 0, 0, 1);
        step("ml_h2",   alu(5'd7, 5'd2, 5'd2), 1, 0, 1, 0, 0, 2);
        step("ml_h3",   alu(5'd7, 5'd2, 5'd2), 1, 0, 1, 0, 0, 3);
        step("ml_bub",  alu(5'd7, 5'd2, 5'd2), 1, 1, 0, 0, 0, 4);
        step("ml_go",   alu(5'd7, 5'd2, 5'd2), 0, 0, 0, 0, 0, 5);
        step("ml_ex",   nop(),                 0, 1, 0, 2, 2, 5);

        // mult bubbles the MEM slot
        step("mb_add",  alu(5'd9, 5'd1, 5'd2),   0, 0, 0, 0, 0, 5);
        step("mb_mul",  mul(5'd10, 5'd1, 5'd2),  0, 0, 0, 0, 0, 5);
        step("mb_h1",   alu(5'd11, 5'd9, 5'd10), 1, 0, 1, 0, 0, 5);
        step("mb_h2",   alu(5'd11, 5'd9, 5'd10), 1, 0, 1, 0, 0, 6);
        step("mb_h3",   alu(5'd11, 5'd9, 5'd10), 1, 0, 1, 0, 0, 7);
        step("mb_go",   alu(5'd11, 5'd9, 5'd10), 0, 0, 0, 0, 0, 8);
        step("mb_ex",   nop(),                   0, 1, 0, 0, 1, 8);

        // reset on second hold cycle
        step("rh_mul",  mul(5'd12, 5'd1, 5'd2), 0, 0, 0, 0, 0, 8);
        step("rh_h1",   nop(),                  1, 0, 1, 0, 0, 8);
        rst = 1'b1;
        step("rh_h2",   nop(),                  1, 0, 1, 0, 0, 9);
        rst = 1'b0;
        step("rh_post", alu(5'd1, 5'd2, 5'd3),  0, 0, 0, 0, 0, 0);

        // counter saturation
        ec = 0;
        for (int k = 0; k < 6; k++) begin
            step("sat_mul", mul(5'd12, 5'd13, 5'd14), 0, 0, 0, 0, 0, CW'(ec));
            for (int h = 0; h < 3; h++) begin
                step("sat_h", nop(), 1, 0, 1, 0, 0, CW'(ec));
                if (ec < 15) ec++;
            end
        end
        step("sat_end", nop(), 0, 1, 0, 0, 0, 4'd15);

        chk("sb", "empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
